pipe_result_fifo: RTL and testbench
===================================

// Module: pipe_result_fifo
// PURPOSE
//  Downstream consumer of the F = (A+B+C-D)*D arithmetic pipeline.
//  - Tracks which launched operand sets are valid, delaying in_valid by the pipeline latency to align with F.
//  - Buffers the aligned results in a DEPTH-entry FIFO.
//  - Presents results to the next stage on a valid/ready interface, with occupancy and a sticky overflow flag.
// PARAMETERS
//  N      10  result width; equals the pipeline's N
//  LAT     3  pipeline latency in clk edges, from operand sample to F valid; LAT >= 1
//  DEPTH   8  FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              high in the cycle A..D are presented to the pipeline
//  f_in       in   N              pipeline output F
//  out_data   out  N              head-of-FIFO result
//  out_valid  out  1              out_data holds a valid result
//  out_ready  in   1              consumer accepts out_data this cycle
//  count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  full       out  1              count == DEPTH
//  overflow   out  1              sticky: a result was dropped
//  clr_ovf    in   1              synchronous clear of overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): delay line, pointers and count cleared.
//    - out_valid=0, count=0, full=0, overflow=0, out_data=0.
//    - In-flight results are discarded; no write occurs for LAT edges after release unless in_valid is re-asserted.
//  - Alignment: in_valid sampled high at edge k gives wr_req=1 at edge k+LAT; f_in is captured at that edge.
//    - wr_req is a LAT-stage shift register; back-to-back in_valid yields back-to-back writes.
//  - Read: rd = out_valid & out_ready. Head advances at the edge.
//    - out_data is combinational from mem[rd_ptr] (first-word fall-through); it is 0 when empty.
//  - Write: wr = wr_req & (~full | rd). A write to a full FIFO succeeds if a read happens at the same edge.
//  - Drop: wr_req & full & ~rd sets overflow at that edge; the data is lost and FIFO state is unchanged.
//  - Overflow clear: clr_ovf clears overflow. If a drop and clr_ovf coincide, set wins.
//  - Empty plus simultaneous wr_req and out_ready: no read (out_valid=0); the write lands and out_valid=1 next cycle. No bypass.
//  - count: +1 on wr only, -1 on rd only, unchanged on both or neither. full is derived from count.
//  - Pointers: $clog2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0.
//  - Flags: out_valid = (count != 0). All flags are registered or derived from registered count; no combinational path from out_ready to out_valid.
//  - Data: f_in is stored unmodified, N bits (modulo 2^N result from the pipeline).
// STRUCTURE
//  - Shared package: N and LAT defaults matching the pipeline, DEPTH default, and the count width function.
//  - One sub-module, valid_delay (parameter LAT; ports clk, rst_n, d, q): async-reset shift register producing wr_req.
//  - FIFO storage, pointers, count and flags live in this module.
//  - Storage is a reg array without reset; only control state is reset.
// TESTING (bench drives pipeline + this block, clk period 20)
//  1. Latency: A,B,C,D=1,2,3,4 with one in_valid pulse at edge k, out_ready=0
//     -> out_valid rises after edge k+LAT; out_data=8, count=1.
//  2. Stream: 3 consecutive sets (1,2,3,4),(0,3,5,2),(2,2,2,2), out_ready=1
//     -> out_data sequence 8,12,8 on consecutive cycles; count never exceeds 1.
//  3. Fill/overflow: 9 back-to-back valid sets (1,0,1,1), out_ready=0
//     -> full=1 after 8th write, 9th dropped, overflow=1, count=8; 8 reads return 1 each, then out_valid=0.
//  4. Full + simultaneous read/write: FIFO full, out_ready=1 while wr_req=1
//     -> count stays 8, overflow stays 0, order preserved across pointer wrap.
//  5. Clear: overflow=1, pulse clr_ovf -> overflow=0. Drop with clr_ovf high in the same cycle -> overflow=1.
//  6. Reset mid-operation: rst_n low for 5 time units with count=3 and 2 results in flight
//     -> out_valid=0, count=0 immediately; no stray writes after release.

Source files
------------

// File: rtl/pipe_result_fifo_pkg.sv
// Shared defaults for the result FIFO, matched to the F = (A+B+C-D)*D pipeline.
package pipe_result_fifo_pkg;

  localparam int N_DEF     = 10;
  localparam int LAT_DEF   = 3;
  localparam int DEPTH_DEF = 8;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// LAT-stage shift register that lines up in_valid with the pipeline output F.
module valid_delay
  import pipe_result_fifo_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d;
    for (int i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[LAT-1];

endmodule

// File: rtl/pipe_result_fifo.sv
// Captures aligned pipeline results into a first-word fall-through FIFO with
// valid/ready output, occupancy count and a sticky overflow flag.
module pipe_result_fifo
  import pipe_result_fifo_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [N-1:0]              f_in,
  output logic [N-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  // Handshake: a result transfers at a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  logic          wr_req;
  logic          rd;
  logic          wr;
  logic          drop;
  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  valid_delay #(.LAT(LAT)) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_valid),
    .q     (wr_req)
  );

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign rd        = out_valid & out_ready;
  // A full FIFO still accepts a write when the head leaves at the same edge.
  assign wr        = wr_req & (~full | rd);
  assign drop      = wr_req & full & ~rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr_q] <= f_in;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pipe_result_fifo.sv
// Bench for pipe_result_fifo: drives a behavioural F pipeline plus the FIFO and
// checks it against a queue-based reference.
module tb_pipe_result_fifo;
  import pipe_result_fifo_pkg::*;

  localparam int N     = N_DEF;
  localparam int LAT   = LAT_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int CW    = cnt_w(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  f_in;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          clr_ovf;

  logic [N-1:0]  op_a, op_b, op_c, op_d;

  int            n_tests;
  int            n_fail;
  logic          chk_en;
  int            max_cnt;

  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  acc_q[$];
  logic [LAT-1:0] m_vld;
  logic [N-1:0]  m_f [LAT];
  logic          m_ovf;
  logic [N-1:0]  pf [LAT];

  pipe_result_fifo #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .f_in      (f_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [N-1:0] f_calc(input logic [N-1:0] a, b, c, d);
    logic [31:0] s;
    s = 32'(a) + 32'(b) + 32'(c) - 32'(d);
    return N'(s * 32'(d));
  endfunction

  // Behavioural arithmetic pipeline feeding f_in (data only, no reset).
  always @(posedge clk) begin
    pf[0] <= f_calc(op_a, op_b, op_c, op_d);
    for (int i = 1; i < LAT; i++) pf[i] <= pf[i-1];
  end
  assign f_in = pf[LAT-1];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: expected results enter exp_q when their write is due, leave on a read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      m_ovf <= 1'b0;
      exp_q.delete();
    end else begin
      logic rd_m, wr_req_m, full_m;
      rd_m     = (exp_q.size() != 0) && out_ready;
      wr_req_m = m_vld[LAT-1];
      full_m   = (exp_q.size() == DEPTH);
      if (rd_m) void'(exp_q.pop_front());
      if (wr_req_m && (!full_m || rd_m)) exp_q.push_back(m_f[LAT-1]);
      if (wr_req_m && full_m && !rd_m) m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
      m_vld <= {m_vld[LAT-2:0], in_valid};
      m_f[0] <= f_calc(op_a, op_b, op_c, op_d);
      for (int i = 1; i < LAT; i++) m_f[i] <= m_f[i-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_data", 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      if (out_valid && out_ready) acc_q.push_back(out_data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d);
    op_a = N'(a);
    op_b = N'(b);
    op_c = N'(c);
    op_d = N'(d);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    steps(DEPTH + 1);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_vals[12];
    n_tests   = 0;
    n_fail    = 0;
    chk_en    = 1'b0;
    max_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    set_ops(0, 0, 0, 0);
    steps(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // Latency: one pulse, result appears after edge k+LAT.
    set_ops(1, 2, 3, 4);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    steps(LAT - 1);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'd8);
    chk("lat_count", 32'(count), 32'd1);
    drain();

    // Stream with consumer always ready.
    acc_q.delete();
    max_cnt   = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_ops(1, 2, 3, 4); step();
    set_ops(0, 3, 5, 2); step();
    set_ops(2, 2, 2, 2); step();
    in_valid = 1'b0;
    steps(LAT + 2);
    out_ready = 1'b0;
    chk("stream_len", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("stream_0", 32'(acc_q[0]), 32'd8);
      chk("stream_1", 32'(acc_q[1]), 32'd12);
      chk("stream_2", 32'(acc_q[2]), 32'd8);
    end
    chk("stream_max_le1", 32'(max_cnt <= 1), 32'd1);

    // Fill past capacity: ninth result is dropped.
    set_ops(1, 0, 1, 1);
    in_valid = 1'b1;
    steps(DEPTH + 1);
    in_valid = 1'b0;
    steps(LAT);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_ovf", 32'(overflow), 32'd1);
    acc_q.delete();
    out_ready = 1'b1;
    steps(DEPTH);
    out_ready = 1'b0;
    chk("fill_reads", 32'(acc_q.size()), 32'(DEPTH));
    foreach (acc_q[i]) chk("fill_rd_val", 32'(acc_q[i]), 32'd1);
    chk("fill_empty", 32'(out_valid), 32'd0);
    chk("fill_ovf_sticky", 32'(overflow), 32'd1);

    // Clear of sticky overflow.
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous read/write, across pointer wrap.
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_ops(10 + i, 0, 0, 1);
      step();
    end
    in_valid = 1'b0;
    steps(LAT);
    chk("rw_full", 32'(count), 32'(DEPTH));
    acc_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ops(20 + i, 0, 0, 1);
      if (i == LAT) out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_count", 32'(count), 32'(DEPTH));
    end
    out_ready = 1'b0;
    chk("rw_ovf", 32'(overflow), 32'd0);
    drain();
    for (int i = 0; i < 8; i++) exp_vals[i] = 9 + i;
    for (int i = 0; i < 4; i++) exp_vals[8 + i] = 19 + i;
    chk("rw_len", 32'(acc_q.size()), 32'd12);
    if (acc_q.size() == 12) begin
      for (int i = 0; i < 12; i++) chk("rw_order", 32'(acc_q[i]), 32'(exp_vals[i]));
    end

    // Drop coinciding with clr_ovf: set wins.
    set_ops(1, 0, 1, 1);
    in_valid = 1'b1;
    steps(DEPTH + 1);
    in_valid = 1'b0;
    steps(LAT - 1);
    chk("dropclr_pre", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("dropclr_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("dropclr_clear", 32'(overflow), 32'd0);
    drain();

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 9) == 0);
      set_ops($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31));
      step();
    end
    in_valid  = 1'b0;
    clr_ovf   = 1'b0;
    steps(LAT);
    drain();

    // Reset mid-operation: count 3 and two results in flight.
    set_ops(3, 3, 3, 3);
    in_valid = 1'b1;
    steps(5);
    in_valid = 1'b0;
    step();
    chk("rst_mid_pre", 32'(count), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    #3;
    rst_n = 1'b1;
    steps(LAT + 3);
    chk("rst_no_stray", 32'(count), 32'd0);
    chk("rst_no_valid", 32'(out_valid), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
